// File: rtl/inert_pkg.sv
// Shared state encoding and sensor command words for the inertial front end.
package inert_pkg;

    typedef logic [2:0] state_t;

    localparam state_t PWR_UP   = 3'd0;
    localparam state_t INIT     = 3'd1;
    localparam state_t WAIT_INT = 3'd2;
    localparam state_t RD_PL    = 3'd3;
    localparam state_t RD_PH    = 3'd4;
    localparam state_t RD_AZL   = 3'd5;
    localparam state_t RD_AZH   = 3'd6;
    localparam state_t VLD      = 3'd7;

    localparam logic [15:0] CMD_INT_CFG = 16'h0D02;
    localparam logic [15:0] CMD_ACC_CFG = 16'h1053;
    localparam logic [15:0] CMD_GYR_CFG = 16'h1150;
    localparam logic [15:0] CMD_ROUND   = 16'h1460;

    // Read commands: bit 15 set selects a register read; low byte is a dummy.
    localparam logic [15:0] RD_PTCH_L = 16'hA200;
    localparam logic [15:0] RD_PTCH_H = 16'hA300;
    localparam logic [15:0] RD_AZ_L   = 16'hAC00;
    localparam logic [15:0] RD_AZ_H   = 16'hAD00;

    function automatic logic [15:0] init_cmd(input logic [1:0] idx);
        logic [15:0] cmd;
        case (idx)
            2'd0:    cmd = CMD_INT_CFG;
            2'd1:    cmd = CMD_ACC_CFG;
            2'd2:    cmd = CMD_GYR_CFG;
            default: cmd = CMD_ROUND;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/inert_intf_if.sv
// Sensor pins plus the sample output bus of the inertial front end.
interface inert_intf_if;

    logic        INT;
    logic        MISO;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;

    modport master (
        input  INT,
        input  MISO,
        output SS_n,
        output SCLK,
        output MOSI,
        output vld,
        output ptch_rt,
        output AZ
    );

    modport slave (
        output INT,
        output MISO,
        input  SS_n,
        input  SCLK,
        input  MOSI,
        input  vld,
        input  ptch_rt,
        input  AZ
    );

endinterface

// File: rtl/spi_mnrch.sv
// 16-bit SPI master, mode 3, MSB first; SS_n is low for exactly 16 SCLK periods.
module spi_mnrch #(
    parameter int unsigned SCLK_DIV_BITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam logic [SCLK_DIV_BITS-1:0] DIV_ONE  = {{(SCLK_DIV_BITS-1){1'b0}}, 1'b1};
    localparam logic [SCLK_DIV_BITS-1:0] DIV_HALF = {1'b0, {(SCLK_DIV_BITS-1){1'b1}}};
    localparam logic [SCLK_DIV_BITS-1:0] DIV_MAX  = {SCLK_DIV_BITS{1'b1}};

    logic                     ss_n_q;
    logic                     sclk_q;
    logic                     done_q;
    logic                     miso_smp_q;
    logic [SCLK_DIV_BITS-1:0] div_q;
    logic [3:0]               bit_cnt_q;
    logic [15:0]              shreg_q;

    // Each bit period: SCLK low for the first half, high for the second. The first
    // falling edge coincides with SS_n dropping, so bit 15 is on MOSI from the start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n_q     <= 1'b1;
            sclk_q     <= 1'b1;
            done_q     <= 1'b0;
            miso_smp_q <= 1'b0;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (ss_n_q) begin
                if (wrt) begin
                    ss_n_q    <= 1'b0;
                    sclk_q    <= 1'b0;
                    div_q     <= '0;
                    bit_cnt_q <= '0;
                    shreg_q   <= wt_data;
                end
            end else begin
                div_q <= div_q + DIV_ONE;
                if (div_q == DIV_HALF) begin
                    sclk_q     <= 1'b1;
                    miso_smp_q <= MISO;
                end else if (div_q == DIV_MAX) begin
                    shreg_q <= {shreg_q[14:0], miso_smp_q};
                    if (bit_cnt_q == 4'hF) begin
                        ss_n_q <= 1'b1;
                        done_q <= 1'b1;
                    end else begin
                        sclk_q    <= 1'b0;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                end
            end
        end
    end

    assign SS_n    = ss_n_q;
    assign SCLK    = sclk_q;
    assign MOSI    = ~ss_n_q & shreg_q[15];
    assign done    = done_q;
    assign rd_data = shreg_q;

endmodule

// File: rtl/inert_intf.sv
// Inertial sensor front end: powers up, configures the sensor, then reads pitch rate
// and Z acceleration on every data-ready interrupt.
module inert_intf
    import inert_pkg::*;
#(
    parameter int unsigned PWR_UP_BITS   = 16,
    parameter int unsigned SCLK_DIV_BITS = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    inert_intf_if.master  ifc
);

    localparam logic [PWR_UP_BITS-1:0] TMR_ONE = {{(PWR_UP_BITS-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic                   int_ff1_q, int_ff2_q;
    logic                   started_q;
    logic [1:0]             init_idx_q;
    logic [PWR_UP_BITS-1:0] pwr_tmr_q;
    logic [7:0]             pl_q, ph_q, azl_q, azh_q;
    logic [15:0]            ptch_q, az_q;
    logic                   vld_q;

    logic                   wrt;
    logic [15:0]            wt_data;
    logic                   spi_done;
    logic [15:0]            rd_data;
    logic                   unused_rd_hi;

    // Upper response byte is clocked out while the command goes in and carries no data.
    assign unused_rd_hi = ^rd_data[15:8];

    spi_mnrch #(
        .SCLK_DIV_BITS(SCLK_DIV_BITS)
    ) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .wt_data (wt_data),
        .done    (spi_done),
        .rd_data (rd_data),
        .SS_n    (ifc.SS_n),
        .SCLK    (ifc.SCLK),
        .MOSI    (ifc.MOSI),
        .MISO    (ifc.MISO)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ff1_q <= 1'b0;
            int_ff2_q <= 1'b0;
        end else begin
            int_ff1_q <= ifc.INT;
            int_ff2_q <= int_ff1_q;
        end
    end

    // Every transfer state issues one wrt on entry and advances on done.
    always_comb begin
        state_d = state_q;
        wrt     = 1'b0;
        wt_data = 16'h0000;
        case (state_q)
            PWR_UP: begin
                if (&pwr_tmr_q) state_d = INIT;
            end
            INIT: begin
                wt_data = init_cmd(init_idx_q);
                wrt     = ~started_q;
                if (spi_done && (init_idx_q == 2'd3)) state_d = WAIT_INT;
            end
            WAIT_INT: begin
                if (int_ff2_q) state_d = RD_PL;
            end
            RD_PL: begin
                wt_data = RD_PTCH_L;
                wrt     = ~started_q;
                if (spi_done) state_d = RD_PH;
            end
            RD_PH: begin
                wt_data = RD_PTCH_H;
                wrt     = ~started_q;
                if (spi_done) state_d = RD_AZL;
            end
            RD_AZL: begin
                wt_data = RD_AZ_L;
                wrt     = ~started_q;
                if (spi_done) state_d = RD_AZH;
            end
            RD_AZH: begin
                wt_data = RD_AZ_H;
                wrt     = ~started_q;
                if (spi_done) state_d = VLD;
            end
            VLD: begin
                state_d = WAIT_INT;
            end
            default: state_d = PWR_UP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PWR_UP;
            started_q  <= 1'b0;
            init_idx_q <= 2'd0;
            pwr_tmr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (spi_done) begin
                started_q <= 1'b0;
            end else if (wrt) begin
                started_q <= 1'b1;
            end
            if ((state_q == INIT) && spi_done) init_idx_q <= init_idx_q + 2'd1;
            if ((state_q == PWR_UP) && !(&pwr_tmr_q)) pwr_tmr_q <= pwr_tmr_q + TMR_ONE;
        end
    end

    // Holding bytes keep partial reads off the outputs until all four have landed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl_q  <= 8'h00;
            ph_q  <= 8'h00;
            azl_q <= 8'h00;
            azh_q <= 8'h00;
        end else if (spi_done) begin
            case (state_q)
                RD_PL:   pl_q  <= rd_data[7:0];
                RD_PH:   ph_q  <= rd_data[7:0];
                RD_AZL:  azl_q <= rd_data[7:0];
                RD_AZH:  azh_q <= rd_data[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptch_q <= 16'h0000;
            az_q   <= 16'h0000;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= (state_q == VLD);
            if (state_q == VLD) begin
                ptch_q <= {ph_q, pl_q};
                az_q   <= {azh_q, azl_q};
            end
        end
    end

    assign ifc.vld     = vld_q;
    assign ifc.ptch_rt = ptch_q;
    assign ifc.AZ      = az_q;

endmodule

// File: doc/inert_intf.md
Name: inert_intf

Overview:
- Producer side of the inertial data path. Configures the 6-axis inertial sensor over SPI, waits for its data-ready interrupt, and reads pitch rate and Z acceleration.
- Presents ptch_rt and AZ with a one-cycle vld strobe to the pitch integrator.
- Sits between the sensor pins and the pitch-fusion logic. Owns all SPI traffic to the sensor.

Parameters:
- PWR_UP_BITS, 16, width of the power-up wait counter; the FSM waits 2^PWR_UP_BITS clocks after reset. Benches use 4.
- SCLK_DIV_BITS, 5, SCLK period is 2^SCLK_DIV_BITS clocks (default 32).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- INT  in  1  sensor data-ready, asynchronous, active high
- MISO  in  1  SPI data from sensor
- SS_n  out  1  SPI select, active low
- SCLK  out  1  SPI clock, idles high
- MOSI  out  1  SPI data to sensor
- vld  out  1  one-cycle pulse: new ptch_rt/AZ pair
- ptch_rt  out  16  raw pitch rate, {high byte, low byte}
- AZ  out  16  raw Z accel, {high byte, low byte}

Behaviour:
- Reset values: vld=0, ptch_rt=0, AZ=0, SS_n=1, SCLK=1, MOSI=0. FSM goes to PWR_UP and all counters clear.
- INT passes through a 2-flop synchronizer. Only the synchronized level is used.
- SPI (spi_mnrch): 16-bit transaction, mode 3, MSB first.
  - wrt is a one-cycle pulse that loads wt_data and drops SS_n.
  - MOSI shifts on the SCLK falling edge; MISO is sampled on the rising edge.
  - After 16 bits, SS_n rises and done pulses for one cycle. rd_data[7:0] holds the sensor response byte.
  - wrt while busy is ignored.
- FSM states and transitions:
  - PWR_UP: wait until the timer saturates, then go to INIT.
  - INIT: four writes issued in order, each started with wrt and advanced on done: 0x0D02 (INT on data ready), 0x1053 (accel 208 Hz), 0x1150 (gyro 208 Hz), 0x1460 (rounding).
  - WAIT_INT: on synchronized INT=1, go to read.
  - Read: RD_PL 0xA2xx, RD_PH 0xA3xx, RD_AZL 0xACxx, RD_AZH 0xADxx. Each read's rd_data[7:0] is captured into holding byte regs on its done.
  - VLD: load ptch_rt and AZ from the holding regs and pulse vld. Both outputs change in the same clock as vld. Return to WAIT_INT.
- Outputs hold between vld pulses. Partial read results are never visible on ptch_rt/AZ.
- INT is ignored outside WAIT_INT. No queuing; a missed sample is dropped.
- The sensor clears INT on the high-byte read, so there is no double read. If INT is still high on return to WAIT_INT, a new read starts immediately.
- Latency: WAIT_INT to vld is 4 transactions plus ≤3 cycles (~4×16×32 clocks at default).
- Asynchronous reset mid-transaction: SS_n=1 and SCLK=1 immediately, the FSM returns to PWR_UP, and the full init sequence repeats.
- Timer: PWR_UP_BITS wide, counts only in PWR_UP, saturates (no wrap).

Decomposition:
- Shared package inert_pkg:
  - state enum.
  - command constants CMD_INT_CFG, CMD_ACC_CFG, CMD_GYR_CFG, CMD_ROUND, RD_PTCH_L/H, RD_AZ_L/H.
- Sub-module spi_mnrch:
  - ports: clk, rst_n, wrt, wt_data[15:0], done, rd_data[15:0], SS_n, SCLK, MOSI, MISO.
  - the top-level instantiates one copy.

Test Plan:
- Reset with PWR_UP_BITS=4: SS_n stays 1 for 16 clocks. The next four transactions carry MOSI 0x0D02, 0x1053, 0x1150, 0x1460 in order. vld stays 0.
- Sensor model holds pitch=0x1234 and AZ=0xFEDC, then pulses INT. The bench sees MOSI reads 0xA2,0xA3,0xAC,0xAD, then one vld pulse with ptch_rt=0x1234 and AZ=0xFEDC in that same cycle.
- Two back-to-back samples (0x0001/0x0002, then 0x8000/0x7FFF) give two vld pulses with matching values. Outputs are stable between pulses.
- INT toggled during RD_PH: no extra transaction and no extra vld. The next INT after VLD is serviced normally.
- rst_n dropped mid RD_AZL: SS_n=1 and SCLK=1 within the reset assertion. After release, the full init sequence is re-issued before any read.
- SCLK check: period 32 clocks and idle high. MOSI is stable across every rising edge. SS_n is low for exactly 16 SCLK periods per transaction.
